// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: fetches 16-bit words into the IR, decodes its fields,
// and hands each instruction to the datapath controller with a one-cycle start pulse.
module instr_fetch_unit #(
    parameter int unsigned          PC_WIDTH = 8,
    parameter logic [PC_WIDTH-1:0]  START_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    output logic                mem_req,
    output logic [PC_WIDTH-1:0] mem_addr,
    input  logic [15:0]         mem_rdata,
    input  logic                mem_valid,
    input  logic                w,
    output logic                s,
    input  logic [2:0]          nsel,
    output logic [2:0]          opcode,
    output logic [1:0]          op,
    output logic [1:0]          shift,
    output logic [2:0]          readnum,
    output logic [2:0]          writenum,
    output logic [15:0]         sximm8,
    output logic [15:0]         sximm5,
    output logic [PC_WIDTH-1:0] pc,
    output logic [15:0]         instr_count,
    output logic                halted
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE_CHK,
        S_ISSUE,
        S_BUSY_FIRST,
        S_BUSY,
        S_HALT
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [PC_WIDTH-1:0] r_pc;
    logic [15:0]         r_ir;
    logic [15:0]         r_cnt;
    logic                w_fetch_done;
    logic [2:0]          w_rn;
    logic [2:0]          w_rd;
    logic [2:0]          w_rm;
    logic [2:0]          w_regnum;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // BUSY is split so the controller's decode cycle can never end the instruction early.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:       if (run) w_next = S_FETCH;
            S_FETCH:      if (mem_valid) w_next = S_DECODE_CHK;
            S_DECODE_CHK: w_next = (r_ir[15:13] == 3'b111) ? S_HALT : S_ISSUE;
            S_ISSUE:      if (w) w_next = S_BUSY_FIRST;
            S_BUSY_FIRST: w_next = S_BUSY;
            S_BUSY:       if (w) w_next = run ? S_FETCH : S_IDLE;
            S_HALT:       w_next = S_HALT;
            default:      w_next = S_IDLE;
        endcase
    end

    always_comb begin
        mem_req = (r_state == S_FETCH);
        s       = (r_state == S_ISSUE) && w;
        halted  = (r_state == S_HALT);
    end

    assign w_fetch_done = (r_state == S_FETCH) && mem_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_pc  <= START_PC;
            r_ir  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_fetch_done) begin
                r_ir <= mem_rdata;
                r_pc <= r_pc + PC_WIDTH'(1);
            end
            if (s && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 16'd1;
            end
        end
    end

    assign w_rn = r_ir[10:8];
    assign w_rd = r_ir[7:5];
    assign w_rm = r_ir[2:0];

    always_comb begin
        w_regnum = 3'b000;
        unique case (nsel)
            3'b100:  w_regnum = w_rd;
            3'b010:  w_regnum = w_rn;
            3'b001:  w_regnum = w_rm;
            default: w_regnum = 3'b000;
        endcase
    end

    assign opcode      = r_ir[15:13];
    assign op          = r_ir[12:11];
    assign shift       = r_ir[4:3];
    assign readnum     = w_regnum;
    assign writenum    = w_regnum;
    assign sximm8      = {{8{r_ir[7]}}, r_ir[7:0]};
    assign sximm5      = {{11{r_ir[4]}}, r_ir[4:0]};
    assign mem_addr    = r_pc;
    assign pc          = r_pc;
    assign instr_count = r_cnt;

endmodule
